// File: rtl/wb_write_queue.sv
// rtl/wb_write_queue.sv - In-order write-back queue: up to 3 results in, 2 register-file writes out per cycle.
module wb_write_queue #(
    parameter int DEPTH = 8
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      in0_valid,
    input  logic [4:0]                in0_addr,
    input  logic [31:0]               in0_data,
    input  logic                      in1_valid,
    input  logic [4:0]                in1_addr,
    input  logic [31:0]               in1_data,
    input  logic                      in2_valid,
    input  logic [4:0]                in2_addr,
    input  logic [31:0]               in2_data,
    output logic                      in_ready,
    output logic                      WE1,
    output logic                      WE2,
    output logic [4:0]                Aw1,
    output logic [4:0]                Aw2,
    output logic [31:0]               WD1,
    output logic [31:0]               WD2,
    input  logic [4:0]                q_addr0,
    input  logic [4:0]                q_addr1,
    input  logic [4:0]                q_addr2,
    input  logic [4:0]                q_addr3,
    output logic [3:0]                q_hit,
    output logic [$clog2(DEPTH):0]    count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [4:0]    r_addr [DEPTH];
    logic [31:0]   r_data [DEPTH];
    logic [AW-1:0] r_head, r_tail;
    logic [CW-1:0] r_count;
    logic          r_we1, r_we2;
    logic [4:0]    r_aw1, r_aw2;
    logic [31:0]   r_wd1, r_wd2;

    logic             w_in_ready;
    logic             w_acc0, w_acc1, w_acc2;
    logic [AW-1:0]    w_slot1, w_slot2, w_head1;
    logic [1:0]       w_npush, w_npop;
    logic [DEPTH-1:0] w_occ;
    logic [4:0]       w_q [4];
    logic [3:0]       w_hit;

    assign w_in_ready = (r_count <= CW'(DEPTH - 3));

    // Register-0 writes are dropped here so they never occupy a slot.
    assign w_acc0  = w_in_ready && in0_valid && (in0_addr != 5'd0);
    assign w_acc1  = w_in_ready && in1_valid && (in1_addr != 5'd0);
    assign w_acc2  = w_in_ready && in2_valid && (in2_addr != 5'd0);
    assign w_slot1 = r_tail + AW'(w_acc0);
    assign w_slot2 = r_tail + AW'(w_acc0) + AW'(w_acc1);
    assign w_npush = 2'(w_acc0) + 2'(w_acc1) + 2'(w_acc2);
    assign w_head1 = r_head + AW'(1);

    // A same-address pair drains one at a time so the later value always lands last.
    always_comb begin
        w_npop = 2'd0;
        if (r_count == CW'(1))
            w_npop = 2'd1;
        else if (r_count >= CW'(2))
            w_npop = (r_addr[r_head] == r_addr[w_head1]) ? 2'd1 : 2'd2;
    end

    always_ff @(posedge CLK) begin
        if (w_acc0) begin
            r_addr[r_tail]  <= in0_addr;
            r_data[r_tail]  <= in0_data;
        end
        if (w_acc1) begin
            r_addr[w_slot1] <= in1_addr;
            r_data[w_slot1] <= in1_data;
        end
        if (w_acc2) begin
            r_addr[w_slot2] <= in2_addr;
            r_data[w_slot2] <= in2_data;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_we1   <= 1'b0;
            r_we2   <= 1'b0;
            r_aw1   <= '0;
            r_aw2   <= '0;
            r_wd1   <= '0;
            r_wd2   <= '0;
        end else begin
            r_we1 <= (w_npop != 2'd0);
            r_we2 <= (w_npop == 2'd2);
            if (w_npop != 2'd0) begin
                r_aw1 <= r_addr[r_head];
                r_wd1 <= r_data[r_head];
            end
            if (w_npop == 2'd2) begin
                r_aw2 <= r_addr[w_head1];
                r_wd2 <= r_data[w_head1];
            end
            r_head  <= r_head + AW'(w_npop);
            r_tail  <= r_tail + AW'(w_npush);
            r_count <= r_count + CW'(w_npush) - CW'(w_npop);
        end
    end

    always_comb begin
        for (int e = 0; e < DEPTH; e++)
            w_occ[e] = ({1'b0, AW'(e) - r_head} < r_count);
    end

    assign w_q[0] = q_addr0;
    assign w_q[1] = q_addr1;
    assign w_q[2] = q_addr2;
    assign w_q[3] = q_addr3;

    // Output registers count as pending until the register file has consumed them.
    always_comb begin
        w_hit = '0;
        for (int q = 0; q < 4; q++) begin
            if (w_q[q] != 5'd0) begin
                if (r_we1 && (r_aw1 == w_q[q]))
                    w_hit[q] = 1'b1;
                if (r_we2 && (r_aw2 == w_q[q]))
                    w_hit[q] = 1'b1;
                for (int e = 0; e < DEPTH; e++)
                    if (w_occ[e] && (r_addr[e] == w_q[q]))
                        w_hit[q] = 1'b1;
            end
        end
    end

    assign in_ready = w_in_ready;
    assign count    = r_count;
    assign q_hit    = w_hit;
    assign WE1      = r_we1;
    assign WE2      = r_we2;
    assign Aw1      = r_aw1;
    assign Aw2      = r_aw2;
    assign WD1      = r_wd1;
    assign WD2      = r_wd2;
endmodule

// File: tb/tb_wb_write_queue.sv
// tb/tb_wb_write_queue.sv - Self-checking bench for wb_write_queue with a queue-level reference model.
module tb_wb_write_queue;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          in0_valid, in1_valid, in2_valid;
    logic [4:0]    in0_addr, in1_addr, in2_addr;
    logic [31:0]   in0_data, in1_data, in2_data;
    logic          in_ready;
    logic          WE1, WE2;
    logic [4:0]    Aw1, Aw2;
    logic [31:0]   WD1, WD2;
    logic [4:0]    q_addr0, q_addr1, q_addr2, q_addr3;
    logic [3:0]    q_hit;
    logic [CW-1:0] count;

    wb_write_queue #(.DEPTH(DEPTH)) dut (
        .CLK(CLK), .RST(RST),
        .in0_valid(in0_valid), .in0_addr(in0_addr), .in0_data(in0_data),
        .in1_valid(in1_valid), .in1_addr(in1_addr), .in1_data(in1_data),
        .in2_valid(in2_valid), .in2_addr(in2_addr), .in2_data(in2_data),
        .in_ready(in_ready),
        .WE1(WE1), .WE2(WE2), .Aw1(Aw1), .Aw2(Aw2), .WD1(WD1), .WD2(WD2),
        .q_addr0(q_addr0), .q_addr1(q_addr1), .q_addr2(q_addr2), .q_addr3(q_addr3),
        .q_hit(q_hit), .count(count)
    );

    initial forever #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference: an ordered list of pending writes plus the two port registers.
    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    ent_t        mq[$];
    logic        m_we1 = 1'b0, m_we2 = 1'b0;
    logic [4:0]  m_aw1 = '0, m_aw2 = '0;
    logic [31:0] m_wd1 = '0, m_wd2 = '0;
    logic        m_rdy;
    logic        chk_en = 1'b0;

    task automatic model_step();
        if (RST) begin
            mq.delete();
            m_we1 = 1'b0; m_we2 = 1'b0;
            m_aw1 = '0;   m_aw2 = '0;
            m_wd1 = '0;   m_wd2 = '0;
        end else begin
            m_rdy = (DEPTH - mq.size() >= 3);
            m_we1 = 1'b0;
            m_we2 = 1'b0;
            if (mq.size() >= 1) begin
                m_we1 = 1'b1; m_aw1 = mq[0].a; m_wd1 = mq[0].d;
                if (mq.size() >= 2 && mq[1].a != mq[0].a) begin
                    m_we2 = 1'b1; m_aw2 = mq[1].a; m_wd2 = mq[1].d;
                    void'(mq.pop_front());
                end
                void'(mq.pop_front());
            end
            if (m_rdy) begin
                if (in0_valid && in0_addr != 5'd0) mq.push_back({in0_addr, in0_data});
                if (in1_valid && in1_addr != 5'd0) mq.push_back({in1_addr, in1_data});
                if (in2_valid && in2_addr != 5'd0) mq.push_back({in2_addr, in2_data});
            end
        end
    endtask

    function automatic logic [3:0] exp_hit();
        logic [4:0] qa [4];
        logic [3:0] h;
        h = '0;
        qa[0] = q_addr0; qa[1] = q_addr1; qa[2] = q_addr2; qa[3] = q_addr3;
        for (int i = 0; i < 4; i++) begin
            if (qa[i] != 5'd0) begin
                if (m_we1 && m_aw1 == qa[i]) h[i] = 1'b1;
                if (m_we2 && m_aw2 == qa[i]) h[i] = 1'b1;
                foreach (mq[e]) if (mq[e].a == qa[i]) h[i] = 1'b1;
            end
        end
        return h;
    endfunction

    always @(negedge CLK) begin
        if (chk_en) begin
            chk("cyc_we1", WE1, m_we1);
            chk("cyc_we2", WE2, m_we2);
            chk("cyc_aw1", Aw1, m_aw1);
            chk("cyc_aw2", Aw2, m_aw2);
            chk("cyc_wd1", WD1, m_wd1);
            chk("cyc_wd2", WD2, m_wd2);
            chk("cyc_count", count, mq.size());
            chk("cyc_in_ready", in_ready, (DEPTH - mq.size() >= 3));
            chk("cyc_q_hit", q_hit, exp_hit());
        end
    end

    task automatic tick();
        model_step();
        @(posedge CLK);
        @(negedge CLK);
        #1;
    endtask

    task automatic drive(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                         input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                         input logic v2, input logic [4:0] a2, input logic [31:0] d2);
        in0_valid = v0; in0_addr = a0; in0_data = d0;
        in1_valid = v1; in1_addr = a1; in1_data = d1;
        in2_valid = v2; in2_addr = a2; in2_data = d2;
    endtask

    task automatic clear_in();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    function automatic logic [4:0] faddr(input int n);
        return 5'(1 + n % 31);
    endfunction

    initial begin
        int   k;
        int   t;
        logic r;
        int   cnt_log [5];
        logic rdy_log [5];

        clear_in();
        q_addr0 = '0; q_addr1 = '0; q_addr2 = '0; q_addr3 = '0;
        RST = 1'b1;
        tick(); tick();
        RST = 1'b0;
        chk_en = 1'b1;
        chk("rst0_count", count, 0);
        chk("rst0_in_ready", in_ready, 1);
        chk("rst0_we", {WE1, WE2}, 0);

        // Single write
        q_addr0 = 5'd5;
        drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        tick(); clear_in();
        chk("sw_count", count, 1);
        chk("sw_we1_early", WE1, 0);
        tick();
        chk("sw_we1", WE1, 1);
        chk("sw_aw1", Aw1, 5);
        chk("sw_wd1", WD1, 32'hDEADBEEF);
        chk("sw_we2", WE2, 0);
        chk("sw_hit", q_hit[0], 1);
        tick();
        chk("sw_we1_off", WE1, 0);
        chk("sw_hit_off", q_hit[0], 0);

        // Triple push
        drive(1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22, 1'b1, 5'd3, 32'h33);
        tick(); clear_in();
        chk("tp_count3", count, 3);
        tick();
        chk("tp_count1", count, 1);
        chk("tp_p1", {WE1, Aw1, WD1[7:0]}, {1'b1, 5'd1, 8'h11});
        chk("tp_p2", {WE2, Aw2, WD2[7:0]}, {1'b1, 5'd2, 8'h22});
        tick();
        chk("tp_count0", count, 0);
        chk("tp_p1b", {WE1, Aw1, WD1[7:0]}, {1'b1, 5'd3, 8'h33});
        chk("tp_we2_off", WE2, 0);
        chk("tp_aw2_hold", {Aw2, WD2[7:0]}, {5'd2, 8'h22});

        // Register zero
        q_addr0 = 5'd0; q_addr1 = 5'd7;
        drive(1'b1, 5'd0, 32'h99, 1'b1, 5'd7, 32'h7, 1'b0, 5'd0, 32'd0);
        tick(); clear_in();
        chk("rz_count", count, 1);
        chk("rz_hit", q_hit[1:0], 2'b10);
        tick();
        chk("rz_p1", {WE1, Aw1, WD1[7:0]}, {1'b1, 5'd7, 8'h07});
        chk("rz_we2", WE2, 0);
        chk("rz_hit0", q_hit[0], 0);
        tick();

        // Same address pair drains one per cycle
        q_addr2 = 5'd4;
        drive(1'b1, 5'd4, 32'hA, 1'b1, 5'd4, 32'hB, 1'b0, 5'd0, 32'd0);
        tick(); clear_in();
        chk("sa_count", count, 2);
        tick();
        chk("sa_p1a", {WE1, Aw1, WD1[7:0]}, {1'b1, 5'd4, 8'h0A});
        chk("sa_we2a", WE2, 0);
        chk("sa_hit", q_hit[2], 1);
        tick();
        chk("sa_p1b", {WE1, Aw1, WD1[7:0]}, {1'b1, 5'd4, 8'h0B});
        chk("sa_we2b", WE2, 0);
        tick();

        // Fill and backpressure; producer holds a triple until accepted
        q_addr0 = 5'd1; q_addr1 = 5'd9; q_addr2 = 5'd17; q_addr3 = 5'd30;
        k = 0; t = 0;
        while (k < 12 && t < 200) begin
            drive(1'b1, faddr(3*k),   32'hF000_0000 + 32'(3*k),
                  1'b1, faddr(3*k+1), 32'hF000_0000 + 32'(3*k+1),
                  1'b1, faddr(3*k+2), 32'hF000_0000 + 32'(3*k+2));
            r = in_ready;
            tick();
            t++;
            if (t <= 5) begin
                cnt_log[t-1] = int'(count);
                rdy_log[t-1] = in_ready;
            end
            if (r) k++;
        end
        chk("fill_done", k, 12);
        chk("fill_c1", cnt_log[0], 3);
        chk("fill_c2", cnt_log[1], 4);
        chk("fill_c3", cnt_log[2], 5);
        chk("fill_c4", cnt_log[3], 6);
        chk("fill_c5", cnt_log[4], 4);
        chk("fill_rdy", {rdy_log[0], rdy_log[1], rdy_log[2], rdy_log[3], rdy_log[4]}, 5'b11101);
        clear_in();
        repeat (10) tick();
        chk("fill_drained", count, 0);

        // Mixed traffic with repeated addresses, register 0, and a mid-run reset
        q_addr0 = 5'd1; q_addr1 = 5'd2; q_addr2 = 5'd3; q_addr3 = 5'd4;
        for (int c = 0; c < 40; c++) begin
            drive(((c*7)   % 3) != 0, 5'((c*5)   % 6), 32'(c*16),
                  ((c*7+1) % 3) != 0, 5'((c*5+3) % 6), 32'(c*16+1),
                  ((c*7+2) % 3) != 0, 5'((c*5+6) % 6), 32'(c*16+2));
            RST = (c == 25 || c == 26);
            tick();
            if (c == 26) begin
                chk("rst_we", {WE1, WE2}, 0);
                chk("rst_aw", {Aw1, Aw2}, 0);
                chk("rst_wd1", WD1, 0);
                chk("rst_wd2", WD2, 0);
                chk("rst_count", count, 0);
                chk("rst_in_ready", in_ready, 1);
                chk("rst_q_hit", q_hit, 0);
            end
        end
        RST = 1'b0;
        clear_in();
        repeat (8) tick();
        chk("end_count", count, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
